// File: rtl/adc_spi_sampler_if.sv
// Bus bundle for adc_spi_sampler: trigger/channel request, ADC SPI pins and sample result.
interface adc_spi_sampler_if;
  logic        sample_trigger;
  logic [2:0]  channel;
  logic        adc_dout;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;
  logic [11:0] sample_data;
  logic [2:0]  sample_channel;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  modport master (
    input  sample_trigger, channel, adc_dout,
    output adc_cs_n, adc_sclk, adc_din, sample_data, sample_channel,
           sample_valid, busy, overrun
  );

  modport slave (
    output sample_trigger, channel, adc_dout,
    input  adc_cs_n, adc_sclk, adc_din, sample_data, sample_channel,
           sample_valid, busy, overrun
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// One 16-bit ADC128S022 SPI frame per sample trigger; returns 12-bit result plus channel tag.
// Optional macro ADC_SCAN_EN: internal channel scan counter replaces the channel input.
//   state | meaning
//   IDLE  | waiting for sample_trigger, CS high
//   SETUP | CS low, SCLK high for one half-period
//   SHIFT | 32 SCLK half-periods (16 bits)
//   DONE  | publish result, release CS
module adc_spi_sampler #(
  parameter int unsigned SCLK_HALF = 8,
  parameter int unsigned NUM_CH    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  adc_spi_sampler_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  localparam logic [7:0] HALF_LOAD = 8'(SCLK_HALF - 1);

  state_t      state_q, state_d;
  logic [7:0]  half_cnt_q, half_cnt_d;
  logic [4:0]  edge_cnt_q, edge_cnt_d;
  logic [11:0] shreg_q, shreg_d;
  logic [2:0]  ch_q, ch_d;
  logic [2:0]  prev_ch_q, prev_ch_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic [11:0] data_q, data_d;
  logic [2:0]  sch_q, sch_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;

  logic        tick;
  logic        accept;
  logic [2:0]  addr_sel;

  assign tick   = (half_cnt_q == 8'd0);
  assign accept = (state_q == IDLE) && bus.sample_trigger;

`ifdef ADC_SCAN_EN
  logic [2:0] scan_q, scan_d;

  always_comb begin
    scan_d = scan_q;
    if (accept) scan_d = (scan_q == 3'(NUM_CH - 1)) ? 3'd0 : scan_q + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan_q <= 3'd0;
    else          scan_q <= scan_d;
  end

  assign addr_sel = scan_q;
`else
  assign addr_sel = bus.channel;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample_trigger) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && edge_cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // edge_cnt_q counts SCLK half-period events: even = falling edge, odd = rising edge.
  always_comb begin
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    shreg_d    = shreg_q;
    ch_d       = ch_q;
    prev_ch_d  = prev_ch_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    din_d      = din_q;
    data_d     = data_q;
    sch_d      = sch_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    ovr_d      = bus.sample_trigger && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.sample_trigger) begin
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          ch_d       = addr_sel;
          half_cnt_d = HALF_LOAD;
          edge_cnt_d = 5'd0;
        end
      end
      SETUP, SHIFT: begin
        if (tick) begin
          half_cnt_d = HALF_LOAD;
          if (edge_cnt_q != 5'd31) edge_cnt_d = edge_cnt_q + 5'd1;
          if (!edge_cnt_q[0]) begin
            sclk_d = 1'b0;
            case (edge_cnt_q)
              5'd4:    din_d = ch_q[2];
              5'd6:    din_d = ch_q[1];
              5'd8:    din_d = ch_q[0];
              default: din_d = 1'b0;
            endcase
          end else begin
            sclk_d = 1'b1;
            if (edge_cnt_q >= 5'd9) shreg_d = {shreg_q[10:0], bus.adc_dout};
          end
        end else begin
          half_cnt_d = half_cnt_q - 8'd1;
        end
      end
      DONE: begin
        cs_n_d    = 1'b1;
        busy_d    = 1'b0;
        valid_d   = 1'b1;
        data_d    = shreg_q;
        sch_d     = prev_ch_q;
        prev_ch_d = ch_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt_q <= 8'd0;
      edge_cnt_q <= 5'd0;
      shreg_q    <= 12'd0;
      ch_q       <= 3'd0;
      prev_ch_q  <= 3'd0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      din_q      <= 1'b0;
      data_q     <= 12'd0;
      sch_q      <= 3'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q    <= shreg_d;
      ch_q       <= ch_d;
      prev_ch_q  <= prev_ch_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
      data_q     <= data_d;
      sch_q      <= sch_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.adc_cs_n       = cs_n_q;
  assign bus.adc_sclk       = sclk_q;
  assign bus.adc_din        = din_q;
  assign bus.sample_data    = data_q;
  assign bus.sample_channel = sch_q;
  assign bus.sample_valid   = valid_q;
  assign bus.busy           = busy_q;
  assign bus.overrun        = ovr_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler with a behavioural ADC128S022 model.
module tb_adc_spi_sampler;
  localparam int H      = 8;
  localparam int NUM_CH = 8;
  localparam int FRAME  = 32 * H + 1;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  rep_ch;
    logic [2:0]  addr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  adc_spi_sampler_if bus();

  adc_spi_sampler #(.SCLK_HALF(H), .NUM_CH(NUM_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  int          ovr_q[$];
  exp_t        e;
  int          next_ok = 0;
  logic [2:0]  prev_ch = 3'd0;
  logic [2:0]  scan_m = 3'd0;
  logic [11:0] adc_word = 12'd0;
  int          pulses = 0;
  logic [2:0]  cap_addr = 3'd0;
  int          sclk_falls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ADC model: shifts D11..D0 after falling edges 5..16, captures address bits on rising edges 3..5.
  always @(negedge bus.adc_cs_n) begin
    pulses   = 0;
    cap_addr = 3'd0;
    bus.adc_dout = 1'b0;
  end

  always @(negedge bus.adc_sclk) begin
    sclk_falls++;
    if (!bus.adc_cs_n) begin
      pulses++;
      if (pulses >= 5 && pulses <= 16) bus.adc_dout = adc_word[16 - pulses];
      else                             bus.adc_dout = 1'b0;
    end
  end

  always @(posedge bus.adc_sclk) begin
    if (!bus.adc_cs_n && pulses >= 3 && pulses <= 5) cap_addr[5 - pulses] = bus.adc_din;
  end

  always @(negedge clk) begin
    if (bus.sample_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got data %0h with nothing expected (cycle %0d)", bus.sample_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sample_data",    32'(bus.sample_data),    32'(e.data));
        chk("sample_channel", 32'(bus.sample_channel), 32'(e.rep_ch));
        chk("din_address",    32'(cap_addr),           32'(e.addr));
        chk("sclk_pulses",    32'(pulses),             32'd16);
        chk("valid_latency",  32'(cyc),                32'(e.due));
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: got no valid, expected one at cycle %0d", exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (bus.overrun) begin
      if (ovr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_overrun: got pulse at cycle %0d, expected none", cyc);
      end else begin
        chk("overrun_time", 32'(cyc), 32'(ovr_q.pop_front()));
      end
    end else if (ovr_q.size() > 0 && cyc > ovr_q[0]) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_overrun: got none, expected pulse at cycle %0d", ovr_q[0]);
      void'(ovr_q.pop_front());
    end
  end

  // Issue a one-cycle trigger; the model decides acceptance from the frame length alone.
  task automatic trig(input logic [2:0] ch, input logic [11:0] val);
    int   edge_n;
    exp_t x;
    logic [2:0] addr;
    edge_n = cyc + 1;
    if (edge_n >= next_ok) begin
`ifdef ADC_SCAN_EN
      addr   = scan_m;
      scan_m = (int'(scan_m) == NUM_CH - 1) ? 3'd0 : scan_m + 3'd1;
`else
      addr = ch;
`endif
      x.data   = val;
      x.rep_ch = prev_ch;
      x.addr   = addr;
      x.due    = edge_n + FRAME;
      exp_q.push_back(x);
      prev_ch  = addr;
      adc_word = val;
      next_ok  = edge_n + FRAME + 1;
    end else begin
      ovr_q.push_back(edge_n);
    end
    bus.sample_trigger = 1'b1;
    bus.channel        = ch;
    @(negedge clk);
    bus.sample_trigger = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 4 * FRAME;
    while ((exp_q.size() > 0 || ovr_q.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_pending", 32'(exp_q.size() + ovr_q.size()), 32'd0);
  endtask

  task automatic wait_until(input int target_edge);
    while (cyc + 1 < target_edge) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset_n            = 1'b0;
    bus.sample_trigger = 1'b0;
    bus.channel        = 3'd0;
    bus.adc_dout       = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(50);
    chk("idle_cs_n",    32'(bus.adc_cs_n),       32'd1);
    chk("idle_sclk",    32'(bus.adc_sclk),       32'd1);
    chk("idle_din",     32'(bus.adc_din),        32'd0);
    chk("idle_data",    32'(bus.sample_data),    32'd0);
    chk("idle_channel", 32'(bus.sample_channel), 32'd0);
    chk("idle_valid",   32'(bus.sample_valid),   32'd0);
    chk("idle_busy",    32'(bus.busy),           32'd0);
    chk("idle_overrun", 32'(bus.overrun),        32'd0);
    chk("idle_sclk_activity", 32'(sclk_falls),   32'd0);

    e0 = cyc + 1;
    trig(3'd5, 12'hA5C);
    chk("busy_after_trigger", 32'(bus.busy), 32'd1);
    chk("cs_after_trigger",   32'(bus.adc_cs_n), 32'd0);
    wait_until(e0 + FRAME);
    chk("busy_last_cycle", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy),     32'd0);
    chk("cs_after_done",   32'(bus.adc_cs_n), 32'd1);
    wait_drain();

    idle(10);
    trig(3'd2, 12'h123);
    wait_drain();

    e0 = cyc + 1;
    trig(3'd6, 12'h7E1);
    wait_until(e0 + 100);
    trig(3'd1, 12'hFFF);
    wait_drain();

    e0 = cyc + 1;
    trig(3'd7, 12'h456);
    wait_until(e0 + 120);
    reset_n = 1'b0;
    #1;
    chk("reset_cs_n", 32'(bus.adc_cs_n),     32'd1);
    chk("reset_sclk", 32'(bus.adc_sclk),     32'd1);
    chk("reset_busy", 32'(bus.busy),         32'd0);
    chk("reset_data", 32'(bus.sample_data),  32'd0);
    exp_q.delete();
    ovr_q.delete();
    prev_ch = 3'd0;
    scan_m  = 3'd0;
    next_ok = 0;
    idle(3);
    reset_n = 1'b1;
    idle(FRAME + 20);
    trig(3'd3, 12'h9B4);
    wait_drain();

    // Boundary: trigger coincident with DONE, then the first acceptable cycle.
    e0 = cyc + 1;
    trig(3'd4, 12'h0F0);
    wait_until(e0 + FRAME);
    trig(3'd2, 12'h321);
    trig(3'd1, 12'hC3A);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ch;
      logic [11:0] val;
      int          mode;
      ch   = 3'($urandom_range(0, 7));
      val  = 12'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 1 && next_ok > cyc + 2) begin
        wait_until(next_ok - 1);
        trig(3'($urandom_range(0, 7)), 12'($urandom));
        trig(ch, val);
      end else if (mode == 2) begin
        wait_until(next_ok);
        trig(ch, val);
      end else begin
        idle($urandom_range(0, 300));
        trig(ch, val);
      end
    end
    wait_drain();
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
